// File: rtl/hc153_scan_pkg.sv
// -----------------------------------------------------------------------------
// hc153_scan_pkg
// Shared types and constants for the hc153 scan controller.
//   state_t   : scan sequencer states (2 bits)
//   NUM_CH    : channels per hc153 mux section
//   CH_W      : channel index width
//   FRAME_W   : assembled frame width (two sections x NUM_CH)
//   set_bit   : returns a 4-bit shadow word with one channel bit replaced
// -----------------------------------------------------------------------------
package hc153_scan_pkg;

    localparam int NUM_CH  = 4;
    localparam int CH_W    = 2;
    localparam int FRAME_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Replace bit 'idx' of a section shadow word with a freshly sampled value.
    function automatic logic [NUM_CH-1:0] set_bit(input logic [NUM_CH-1:0] word,
                                                  input logic [CH_W-1:0]   idx,
                                                  input logic              val);
        logic [NUM_CH-1:0] res;
        res      = word;
        res[idx] = val;
        return res;
    endfunction

endpackage

// File: rtl/hc153_settle_timer.sv
// -----------------------------------------------------------------------------
// hc153_settle_timer
// Loadable down-counter with a zero flag. Used to hold each select value for
// a fixed number of cycles before the mux outputs are sampled.
// Ports:
//   clk      : clock, rising edge
//   rst_n    : asynchronous active-low reset (count -> 0)
//   load     : load load_val (has priority over dec)
//   load_val : value to load
//   dec      : decrement by one; ignored when already zero
//   zero     : high while the count is zero
// -----------------------------------------------------------------------------
module hc153_settle_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] count_r;

    // Count register: load wins over decrement, saturates at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_r <= {CNT_W{1'b0}};
        end else if (load) begin
            count_r <= load_val;
        end else if (dec && (count_r != {CNT_W{1'b0}})) begin
            count_r <= count_r - CNT_W'(1);
        end else begin
            count_r <= count_r;
        end
    end

    assign zero = (count_r == {CNT_W{1'b0}});

endmodule

// File: rtl/hc153_scan_ctrl.sv
// -----------------------------------------------------------------------------
// hc153_scan_ctrl
// Sequencer that turns an hc153 dual 4:1 mux into a scanned 8-input sampler.
// For each channel 0..3 it drives the A/B selects, waits SETTLE_CYCLES, then
// samples Y1/Y2 into shadow registers. After channel 3 the assembled frame is
// published on data with a one-cycle valid pulse.
//
// Parameters:
//   SETTLE_CYCLES : cycles held on each select before sampling (>= 1)
//   CNT_W         : settle counter width, must hold SETTLE_CYCLES-1
// Ports:
//   sys_clk, sys_rst_n : clock / asynchronous active-low reset
//   run                : scan while high (sampled in IDLE and DONE)
//   y1, y2             : hc153 section outputs
//   sel_a, sel_b       : hc153 channel selects (LSB, MSB)
//   n_g1, n_g2         : hc153 active-low strobes
//   data               : last frame, [3:0]=section 1 ch3..0, [7:4]=section 2
//   valid              : one-cycle pulse when data is updated
//   busy               : high whenever the sequencer is not idle
// Configuration:
//   HC153_SCAN_DEBOUNCE_EN : when defined, a frame is published only if it
//                            equals the previous completed frame.
// -----------------------------------------------------------------------------
module hc153_scan_ctrl
    import hc153_scan_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 4
) (
    input  logic               sys_clk,
    input  logic               sys_rst_n,
    input  logic               run,
    input  logic               y1,
    input  logic               y2,
    output logic               sel_a,
    output logic               sel_b,
    output logic               n_g1,
    output logic               n_g2,
    output logic [FRAME_W-1:0] data,
    output logic               valid,
    output logic               busy
);

    generate
        if (SETTLE_CYCLES < 1) begin : g_bad_settle
            $error("hc153_scan_ctrl: SETTLE_CYCLES must be >= 1");
        end
        if ((CNT_W < 1) || ((SETTLE_CYCLES - 1) >= (1 << CNT_W))) begin : g_bad_cnt_w
            $error("hc153_scan_ctrl: CNT_W too narrow for SETTLE_CYCLES-1");
        end
    endgenerate

    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CH_W-1:0]  LAST_CH     = CH_W'(NUM_CH - 1);

    state_t              state_r;
    state_t              state_nxt_s;
    logic [CH_W-1:0]     ch_r;
    logic [CH_W-1:0]     ch_nxt_s;
    logic [NUM_CH-1:0]   shadow1_r;
    logic [NUM_CH-1:0]   shadow2_r;
    logic [NUM_CH-1:0]   frame1_s;
    logic [NUM_CH-1:0]   frame2_s;
    logic [FRAME_W-1:0]  new_frame_s;
    logic [FRAME_W-1:0]  data_r;
    logic                valid_r;
    logic                busy_r;
    logic                n_g_r;
    logic                load_s;
    logic                dec_s;
    logic                capture_s;
    logic                frame_done_s;
    logic                accept_s;
    logic                zero_s;

    hc153_settle_timer #(
        .CNT_W (CNT_W)
    ) u_settle_timer (
        .clk      (sys_clk),
        .rst_n    (sys_rst_n),
        .load     (load_s),
        .load_val (SETTLE_LOAD),
        .dec      (dec_s),
        .zero     (zero_s)
    );

    // The last channel's sample is merged combinationally so the complete
    // frame can be loaded into data on the same edge that enters DONE.
    assign frame1_s    = set_bit(shadow1_r, ch_r, y1);
    assign frame2_s    = set_bit(shadow2_r, ch_r, y2);
    assign new_frame_s = {frame2_s, frame1_s};

    // Next-state, channel and timer control.
    always_comb begin
        state_nxt_s  = state_r;
        ch_nxt_s     = ch_r;
        load_s       = 1'b0;
        dec_s        = 1'b0;
        capture_s    = 1'b0;
        frame_done_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (run) begin
                    state_nxt_s = SETTLE;
                    ch_nxt_s    = {CH_W{1'b0}};
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SETTLE: begin
                if (zero_s) begin
                    state_nxt_s = SAMPLE;
                end else begin
                    dec_s = 1'b1;
                end
            end
            SAMPLE: begin
                capture_s = 1'b1;
                if (ch_r == LAST_CH) begin
                    state_nxt_s  = DONE;
                    frame_done_s = 1'b1;
                end else begin
                    state_nxt_s = SETTLE;
                    ch_nxt_s    = ch_r + CH_W'(1);
                    load_s      = 1'b1;
                end
            end
            DONE: begin
                // Channel returns to 0 only on the way out of DONE.
                ch_nxt_s = {CH_W{1'b0}};
                if (run) begin
                    state_nxt_s = SETTLE;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
                ch_nxt_s    = {CH_W{1'b0}};
            end
        endcase
    end

`ifdef HC153_SCAN_DEBOUNCE_EN
    logic [FRAME_W-1:0] prev_frame_r;

    assign accept_s = frame_done_s && (new_frame_s == prev_frame_r);

    // Remember every completed frame, accepted or not.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            prev_frame_r <= {FRAME_W{1'b0}};
        end else if (frame_done_s) begin
            prev_frame_r <= new_frame_s;
        end else begin
            prev_frame_r <= prev_frame_r;
        end
    end
`else
    assign accept_s = frame_done_s;
`endif

    // Sequencer state, shadows and registered outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_r   <= IDLE;
            ch_r      <= {CH_W{1'b0}};
            shadow1_r <= {NUM_CH{1'b0}};
            shadow2_r <= {NUM_CH{1'b0}};
            data_r    <= {FRAME_W{1'b0}};
            valid_r   <= 1'b0;
            busy_r    <= 1'b0;
            n_g_r     <= 1'b1;
        end else begin
            state_r <= state_nxt_s;
            ch_r    <= ch_nxt_s;
            if (capture_s) begin
                shadow1_r <= frame1_s;
                shadow2_r <= frame2_s;
            end
            if (accept_s) begin
                data_r <= new_frame_s;
            end
            valid_r <= accept_s;
            busy_r  <= (state_nxt_s != IDLE);
            // Strobes enabled in every non-idle state, including DONE.
            n_g_r   <= (state_nxt_s == IDLE);
        end
    end

    assign sel_a = ch_r[0];
    assign sel_b = ch_r[1];
    assign n_g1  = n_g_r;
    assign n_g2  = n_g_r;
    assign data  = data_r;
    assign valid = valid_r;
    assign busy  = busy_r;

endmodule
